// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer.
// It steps each instruction through fetch, decode, execute, an optional memory
// access and an optional writeback, and counts retired instructions.
// Every output is a flop whose next value is decoded from the next state, so
// each output reflects the registered state and no ack reaches an output
// combinationally. An ack that does not arrive within TIMEOUT cycles sends the
// sequencer to an absorbing TRAP state.
module core_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  output logic            o_decode_en,
  input  logic [6:0]      i_opcode,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  input  logic            i_dmem_ack,
  output logic            o_rf_wen,
  output logic            o_pc_en,
  output logic [2:0]      o_state,
  output logic            o_trap,
  output logic [XLEN-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Last wait-counter value at which an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              store_q, store_d;
  logic              retire_s;
  logic              imem_req_q, imem_req_d;
  logic              decode_en_q, decode_en_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_wen_q, rf_wen_d;
  logic              pc_en_q, pc_en_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   instret_q, instret_d;

  // Next-state, wait-counter and next-output computation.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    store_d  = store_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (i_opcode)
          OP_LOAD: begin
            state_d = S_MEMORY;
            store_d = 1'b0;
            wait_d  = 8'd0;
          end
          OP_STORE: begin
            state_d = S_MEMORY;
            store_d = 1'b1;
            wait_d  = 8'd0;
          end
          OP_OPIMM, OP_JALR, OP_JAL: begin
            state_d = S_WRITEBACK;
          end
          OP_BRANCH: begin
            state_d  = S_FETCH;
            wait_d   = 8'd0;
            retire_s = 1'b1;
          end
          default: begin
            state_d = S_TRAP;
          end
        endcase
      end
      S_MEMORY: begin
        if (i_dmem_ack) begin
          if (store_q) begin
            state_d  = S_FETCH;
            wait_d   = 8'd0;
            retire_s = 1'b1;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    imem_req_d  = (state_d == S_FETCH);
    decode_en_d = (state_d == S_DECODE);
    dmem_req_d  = (state_d == S_MEMORY);
    dmem_we_d   = (state_d == S_MEMORY) && store_d;
    rf_wen_d    = (state_d == S_WRITEBACK);
    pc_en_d     = (state_d == S_WRITEBACK) || retire_s;
    trap_d      = (state_d == S_TRAP);
    instret_d   = instret_q + XLEN'(pc_en_q);
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      store_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      decode_en_q <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_wen_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      trap_q      <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      store_q     <= store_d;
      imem_req_q  <= imem_req_d;
      decode_en_q <= decode_en_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      rf_wen_q    <= rf_wen_d;
      pc_en_q     <= pc_en_d;
      trap_q      <= trap_d;
      instret_q   <= instret_d;
    end
  end

  assign o_imem_req  = imem_req_q;
  assign o_decode_en = decode_en_q;
  assign o_dmem_req  = dmem_req_q;
  assign o_dmem_we   = dmem_we_q;
  assign o_rf_wen    = rf_wen_q;
  assign o_pc_en     = pc_en_q;
  assign o_state     = state_q;
  assign o_trap      = trap_q;
  assign o_instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed instruction sequences with a retire
// scoreboard; expected retire records are queued by the stimulus and popped
// by a monitor whenever the sequencer pulses o_pc_en.
module tb_core_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FET  = 3'd1;
  localparam logic [2:0] ST_DEC  = 3'd2;
  localparam logic [2:0] ST_EXE  = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;
  localparam logic [2:0] ST_TRAP = 3'd6;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_imem_ack = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic [6:0]  i_opcode = 7'd0;
  logic        o_imem_req, o_decode_en, o_dmem_req, o_dmem_we;
  logic        o_rf_wen, o_pc_en, o_trap;
  logic [2:0]  o_state;
  logic [31:0] o_instret;

  typedef struct packed {
    logic       rf;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  core_sequencer #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack),
    .o_decode_en(o_decode_en), .i_opcode(i_opcode),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
    .o_rf_wen(o_rf_wen), .o_pc_en(o_pc_en), .o_state(o_state),
    .o_trap(o_trap), .o_instret(o_instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] strobes();
    return {o_imem_req, o_decode_en, o_dmem_req, o_dmem_we, o_rf_wen, o_pc_en, o_trap};
  endfunction

  // Retire monitor: pops the next expected retire on every o_pc_en pulse.
  always @(negedge clk) begin
    if (rstn && o_pc_en) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("retire_rf_wen", 64'(o_rf_wen), 64'(mon_e.rf));
        check("retire_state", 64'(o_state), 64'(mon_e.st));
      end
    end
    if (rstn && o_rf_wen) check("rf_wen_needs_pc_en", 64'(o_pc_en), 64'd1);
  end

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (o_state !== s && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(o_state), 64'(s));
  endtask

  // From a negedge in FETCH: ack after 'waits' wait cycles, ends at the EXECUTE negedge.
  task automatic do_fetch(input int waits, input logic [6:0] op);
    i_opcode = op;
    wait_state(ST_FET, "fetch_entry");
    for (int i = 0; i < waits; i++) begin
      check("fetch_wait_state", 64'(o_state), 64'(ST_FET));
      @(negedge clk);
    end
    check("fetch_req", 64'(o_imem_req), 64'd1);
    i_imem_ack = 1'b1;
    @(negedge clk);
    i_imem_ack = 1'b0;
    check("decode_state", 64'(o_state), 64'(ST_DEC));
    check("decode_en", 64'(o_decode_en), 64'd1);
    @(negedge clk);
    check("exec_state", 64'(o_state), 64'(ST_EXE));
    check("decode_en_one_cycle", 64'(o_decode_en), 64'd0);
  endtask

  // From the EXECUTE negedge: memory ack after 'waits' wait cycles.
  task automatic do_mem(input int waits, input logic we);
    @(negedge clk);
    check("mem_state", 64'(o_state), 64'(ST_MEM));
    for (int i = 0; i < waits; i++) begin
      check("mem_req", 64'(o_dmem_req), 64'd1);
      check("mem_we", 64'(o_dmem_we), 64'(we));
      @(negedge clk);
    end
    check("mem_we_last", 64'(o_dmem_we), 64'(we));
    i_dmem_ack = 1'b1;
    @(negedge clk);
    i_dmem_ack = 1'b0;
  endtask

  task automatic run_alu(input int fw);
    sb.push_back('{rf: 1'b1, st: ST_WB});
    do_fetch(fw, OPC_OPIMM);
    @(negedge clk);
    check("alu_wb_state", 64'(o_state), 64'(ST_WB));
    @(negedge clk);
    check("alu_back_to_fetch", 64'(o_state), 64'(ST_FET));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 64'(o_state), 64'(ST_IDLE));
    check("rst_strobes", 64'(strobes()), 64'd0);
    check("rst_instret", 64'(o_instret), 64'd0);

    // OpImm with imem ack on the second FETCH cycle: 0,1,1,2,3,5,1
    i_opcode = OPC_OPIMM;
    sb.push_back('{rf: 1'b1, st: ST_WB});
    rstn = 1'b1;
    check("s1_c0", 64'(o_state), 64'(ST_IDLE));
    @(negedge clk); check("s1_c1", 64'(o_state), 64'(ST_FET));
    @(negedge clk); check("s1_c2", 64'(o_state), 64'(ST_FET));
    i_imem_ack = 1'b1;
    @(negedge clk); i_imem_ack = 1'b0; check("s1_c3", 64'(o_state), 64'(ST_DEC));
    @(negedge clk); check("s1_c4", 64'(o_state), 64'(ST_EXE));
    @(negedge clk); check("s1_c5", 64'(o_state), 64'(ST_WB));
    check("s1_rf_pc", 64'({o_rf_wen, o_pc_en}), 64'b11);
    @(negedge clk); check("s1_c6", 64'(o_state), 64'(ST_FET));
    check("s1_instret", 64'(o_instret), 64'd1);

    // Load, dmem ack on the third MEMORY cycle
    sb.push_back('{rf: 1'b1, st: ST_WB});
    do_fetch(0, OPC_LOAD);
    do_mem(2, 1'b0);
    check("load_wb_state", 64'(o_state), 64'(ST_WB));
    @(negedge clk);
    check("load_instret", 64'(o_instret), 64'd2);

    // Store then Branch back-to-back
    sb.push_back('{rf: 1'b0, st: ST_FET});
    do_fetch(0, OPC_STORE);
    do_mem(1, 1'b1);
    check("store_to_fetch", 64'(o_state), 64'(ST_FET));
    sb.push_back('{rf: 1'b0, st: ST_FET});
    do_fetch(0, OPC_BRANCH);
    @(negedge clk);
    check("branch_to_fetch", 64'(o_state), 64'(ST_FET));
    check("branch_pc_en", 64'(o_pc_en), 64'd1);
    check("store_branch_instret_mid", 64'(o_instret), 64'd3);

    // Fetch ack in the timeout cycle (4th FETCH cycle) wins
    run_alu(3);
    check("boundary_instret", 64'(o_instret), 64'd5);
    check("boundary_no_trap", 64'(o_trap), 64'd0);

    // Counter wrap from all-ones
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.instret_q;
    @(negedge clk);
    check("preload_instret", 64'(o_instret), 64'hFFFF_FFFF);
    run_alu(0);
    check("wrap_instret", 64'(o_instret), 64'd0);

    // Asynchronous reset in the middle of a MEMORY access
    do_fetch(0, OPC_LOAD);
    @(negedge clk);
    check("mid_mem_state", 64'(o_state), 64'(ST_MEM));
    @(negedge clk);
    check("mid_mem_req", 64'(o_dmem_req), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_state", 64'(o_state), 64'(ST_IDLE));
    check("async_rst_strobes", 64'(strobes()), 64'd0);
    check("async_rst_instret", 64'(o_instret), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    check("restart_idle", 64'(o_state), 64'(ST_IDLE));
    @(negedge clk);
    check("restart_fetch", 64'(o_state), 64'(ST_FET));

    // No fetch ack: TRAP after four FETCH cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("timeout_still_fetch", 64'(o_state), 64'(ST_FET));
    end
    @(negedge clk);
    check("timeout_trap_state", 64'(o_state), 64'(ST_TRAP));
    check("timeout_trap_strobes", 64'(strobes()), 64'd1);

    // Illegal opcode traps; later acks are ignored
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_fetch(0, OPC_BAD);
    @(negedge clk);
    check("bad_op_trap", 64'(o_state), 64'(ST_TRAP));
    check("bad_op_o_trap", 64'(o_trap), 64'd1);
    for (int i = 0; i < 4; i++) begin
      i_imem_ack = (i % 2 == 0);
      i_dmem_ack = 1'b1;
      @(negedge clk);
      check("trap_absorbing", 64'(o_state), 64'(ST_TRAP));
      check("trap_strobes", 64'(strobes()), 64'd1);
    end
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    check("trap_instret_frozen", 64'(o_instret), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
